// File: rtl/req_ack_mon_pkg.sv
// Shared types and helpers for the req/ack window monitor.
// Fail codes, channel state encoding and the saturating adder used by the
// aggregate counters.
package req_ack_mon_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        EARLY   = 3'd1,
        TIMEOUT = 3'd2,
        OVERLAP = 3'd3,
        STRAY   = 3'd4
    } fail_code_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

    // Add two unsigned values and clamp the result to w bits of all-ones.
    // The sum is held one bit wider than the operands, so it never wraps
    // before the clamp (w is expected to be at most 63).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] lim;
        logic [64:0] sum;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            sat_add = lim;
        end else begin
            sat_add = sum[63:0];
        end
    endfunction

endpackage

// File: rtl/req_ack_window_mon_ch.sv
// One monitor channel: registered rise detection, IDLE/WAIT FSM, latency
// counter and registered pass/fail/code outputs.
// Rises are registered first, so the FSM acts one edge after the input edge
// and its pass/fail registers appear one edge after that -- i.e. on the edge
// following the sampling edge that resolves the check. o_busy exposes the
// FSM state directly (1 = WAIT).
module req_ack_ch_chk
    import req_ack_mon_pkg::*;
#(
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_req,
    input  logic       i_ack,
    output logic       o_busy,
    output logic       o_pass,
    output logic       o_fail,
    output logic [2:0] o_code
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_WAIT = WAIT;

    logic       r_req_q;
    logic       r_ack_q;
    logic       r_req_rise;
    logic       r_ack_rise;
    logic       r_en_q;
    logic [0:0] r_state;
    logic [7:0] r_lat;
    logic       r_pass;
    logic       r_fail;
    logic [2:0] r_code;

    logic [0:0] w_state_nxt;
    logic [7:0] w_lat_nxt;
    logic [8:0] w_lat_now;
    logic       w_pass_nxt;
    logic       w_fail_nxt;
    logic [2:0] w_code_nxt;

    // Cycle index of the edge being evaluated, counted from the req edge.
    assign w_lat_now = {1'b0, r_lat} + 9'd1;

    // Register input levels and their rising edges (levels themselves are ignored).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_q    <= 1'b0;
            r_ack_q    <= 1'b0;
            r_req_rise <= 1'b0;
            r_ack_rise <= 1'b0;
            r_en_q     <= 1'b0;
        end else begin
            r_req_q    <= i_req;
            r_ack_q    <= i_ack;
            r_req_rise <= i_req & ~r_req_q;
            r_ack_rise <= i_ack & ~r_ack_q;
            r_en_q     <= i_en;
        end
    end

    // Classify the current edge: resolution (pass/early/timeout) beats overlap.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_pass_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        w_code_nxt  = NONE;
        case (r_state)
            S_IDLE: begin
                if (r_ack_rise) begin
                    w_fail_nxt = 1'b1;
                    w_code_nxt = STRAY;
                end
                if (r_req_rise && r_en_q) begin
                    w_state_nxt = S_WAIT;
                    w_lat_nxt   = 8'd0;
                end
            end
            S_WAIT: begin
                w_lat_nxt = w_lat_now[7:0];
                if (r_ack_rise) begin
                    w_state_nxt = S_IDLE;
                    if (w_lat_now < 9'(MIN_LAT)) begin
                        w_fail_nxt = 1'b1;
                        w_code_nxt = EARLY;
                    end else begin
                        w_pass_nxt = 1'b1;
                    end
                end else if (w_lat_now == 9'(MAX_LAT)) begin
                    w_state_nxt = S_IDLE;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = TIMEOUT;
                end else if (r_req_rise) begin
                    w_fail_nxt = 1'b1;
                    w_code_nxt = OVERLAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, latency counter and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_lat   <= 8'd0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_code  <= NONE;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign o_busy = (r_state == S_WAIT);
    assign o_pass = r_pass;
    assign o_fail = r_fail;
    assign o_code = r_code;

endmodule

// File: rtl/req_ack_window_mon.sv
// Multi-channel req/ack window monitor top.
// Instantiates one req_ack_ch_chk per channel and keeps saturating
// aggregate pass/fail counts. Defining REQ_ACK_MON_STICKY_EN adds
// err_clr_i / err_sticky_o: a per-channel sticky fail flag (set wins over clear).
module req_ack_window_mon
    import req_ack_mon_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [NUM_CH-1:0]     req_i,
    input  logic [NUM_CH-1:0]     ack_i,
`ifdef REQ_ACK_MON_STICKY_EN
    input  logic                  err_clr_i,
    output logic [NUM_CH-1:0]     err_sticky_o,
`endif
    output logic [NUM_CH-1:0]     busy_o,
    output logic [NUM_CH-1:0]     pass_o,
    output logic [NUM_CH-1:0]     fail_o,
    output logic [3*NUM_CH-1:0]   fail_code_o,
    output logic [CNT_W-1:0]      pass_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o
);

    localparam int POP_W = $clog2(NUM_CH + 1);

    logic [POP_W-1:0] w_pass_pop;
    logic [POP_W-1:0] w_fail_pop;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_ack_ch_chk #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_en   (en_i),
            .i_req  (req_i[g]),
            .i_ack  (ack_i[g]),
            .o_busy (busy_o[g]),
            .o_pass (pass_o[g]),
            .o_fail (fail_o[g]),
            .o_code (fail_code_o[3*g +: 3])
        );
    end

    // Count this cycle's pass and fail pulses across channels.
    always_comb begin
        w_pass_pop = '0;
        w_fail_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pass_pop = w_pass_pop + POP_W'(pass_o[i]);
            w_fail_pop = w_fail_pop + POP_W'(fail_o[i]);
        end
    end

    // Aggregate counters clamp at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_pass_cnt <= CNT_W'(sat_add(64'(r_pass_cnt), 64'(w_pass_pop), CNT_W));
            r_fail_cnt <= CNT_W'(sat_add(64'(r_fail_cnt), 64'(w_fail_pop), CNT_W));
        end
    end

    assign pass_cnt_o = r_pass_cnt;
    assign fail_cnt_o = r_fail_cnt;

`ifdef REQ_ACK_MON_STICKY_EN
    logic [NUM_CH-1:0] r_sticky;

    // Sticky error flags: a fail pulse sets, err_clr_i clears, set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~{NUM_CH{err_clr_i}}) | fail_o;
        end
    end

    assign err_sticky_o = r_sticky;
`endif

endmodule

// File: tb/tb_req_ack_window_mon.sv
// Self-checking bench for req_ack_window_mon (MIN_LAT=2, MAX_LAT=4, CNT_W=4
// so that window boundaries and counter saturation are reached quickly).
// Build with +define+REQ_ACK_MON_STICKY_EN to exercise the sticky flags.
module tb_req_ack_window_mon;

  localparam int NUM_CH  = 2;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                en_i;
  logic [NUM_CH-1:0]   req_i;
  logic [NUM_CH-1:0]   ack_i;
  logic [NUM_CH-1:0]   busy_o;
  logic [NUM_CH-1:0]   pass_o;
  logic [NUM_CH-1:0]   fail_o;
  logic [3*NUM_CH-1:0] fail_code_o;
  logic [CNT_W-1:0]    pass_cnt_o;
  logic [CNT_W-1:0]    fail_cnt_o;
`ifdef REQ_ACK_MON_STICKY_EN
  logic                err_clr_i;
  logic [NUM_CH-1:0]   err_sticky_o;
`endif

  always #5 clk = ~clk;

  req_ack_window_mon #(
    .NUM_CH  (NUM_CH),
    .MIN_LAT (MIN_LAT),
    .MAX_LAT (MAX_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .req_i        (req_i),
    .ack_i        (ack_i),
`ifdef REQ_ACK_MON_STICKY_EN
    .err_clr_i    (err_clr_i),
    .err_sticky_o (err_sticky_o),
`endif
    .busy_o       (busy_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .fail_code_o  (fail_code_o),
    .pass_cnt_o   (pass_cnt_o),
    .fail_cnt_o   (fail_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: per channel, is a transaction open and at which
  // sampled edge did it start. Outputs are predicted one edge ahead.
  bit                  m_active [NUM_CH];
  int                  m_start  [NUM_CH];
  int                  m_n;
  logic [NUM_CH-1:0]   m_req_prev;
  logic [NUM_CH-1:0]   m_ack_prev;
  logic [NUM_CH-1:0]   exp_busy;
  logic [NUM_CH-1:0]   exp_pass;
  logic [NUM_CH-1:0]   exp_fail;
  logic [3*NUM_CH-1:0] exp_code;
  int                  exp_pcnt;
  int                  exp_fcnt;
  logic [NUM_CH-1:0]   exp_sticky;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_active[c] = 1'b0;
      m_start[c]  = 0;
    end
    m_n        = 0;
    m_req_prev = '0;
    m_ack_prev = '0;
    exp_busy   = '0;
    exp_pass   = '0;
    exp_fail   = '0;
    exp_code   = '0;
    exp_pcnt   = 0;
    exp_fcnt   = 0;
    exp_sticky = '0;
  endtask

  // Apply the rules to the inputs sampled at the last edge; results are
  // what the DUT must show after the next edge.
  task automatic model_edge();
    logic rr, ar;
    int   lat;
    exp_pcnt = exp_pcnt + $countones(exp_pass);
    if (exp_pcnt > CNT_MAX) exp_pcnt = CNT_MAX;
    exp_fcnt = exp_fcnt + $countones(exp_fail);
    if (exp_fcnt > CNT_MAX) exp_fcnt = CNT_MAX;
`ifdef REQ_ACK_MON_STICKY_EN
    exp_sticky = (err_clr_i ? '0 : exp_sticky) | exp_fail;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      rr = req_i[c] & ~m_req_prev[c];
      ar = ack_i[c] & ~m_ack_prev[c];
      exp_pass[c] = 1'b0;
      exp_fail[c] = 1'b0;
      exp_code[3*c +: 3] = 3'd0;
      if (m_active[c]) begin
        lat = m_n - m_start[c];
        if (ar) begin
          m_active[c] = 1'b0;
          if (lat < MIN_LAT) begin
            exp_fail[c] = 1'b1;
            exp_code[3*c +: 3] = 3'd1;
          end else begin
            exp_pass[c] = 1'b1;
          end
        end else if (lat == MAX_LAT) begin
          m_active[c] = 1'b0;
          exp_fail[c] = 1'b1;
          exp_code[3*c +: 3] = 3'd2;
        end else if (rr) begin
          exp_fail[c] = 1'b1;
          exp_code[3*c +: 3] = 3'd3;
        end
      end else begin
        if (ar) begin
          exp_fail[c] = 1'b1;
          exp_code[3*c +: 3] = 3'd4;
        end
        if (rr && en_i) begin
          m_active[c] = 1'b1;
          m_start[c]  = m_n;
        end
      end
      exp_busy[c] = m_active[c];
    end
    m_req_prev = req_i;
    m_ack_prev = ack_i;
    m_n++;
  endtask

  task automatic compare_all();
    check("busy_o", 64'(busy_o), 64'(exp_busy));
    check("pass_o", 64'(pass_o), 64'(exp_pass));
    check("fail_o", 64'(fail_o), 64'(exp_fail));
    check("fail_code_o", 64'(fail_code_o), 64'(exp_code));
    check("pass_cnt_o", 64'(pass_cnt_o), 64'(exp_pcnt));
    check("fail_cnt_o", 64'(fail_cnt_o), 64'(exp_fcnt));
`ifdef REQ_ACK_MON_STICKY_EN
    check("err_sticky_o", 64'(err_sticky_o), 64'(exp_sticky));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_pass"}, 64'(pass_o), 64'd0);
    check({tag, "_fail"}, 64'(fail_o), 64'd0);
    check({tag, "_code"}, 64'(fail_code_o), 64'd0);
    check({tag, "_pcnt"}, 64'(pass_cnt_o), 64'd0);
    check({tag, "_fcnt"}, 64'(fail_cnt_o), 64'd0);
`ifdef REQ_ACK_MON_STICKY_EN
    check({tag, "_sticky"}, 64'(err_sticky_o), 64'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NUM_CH-1:0] rq, input logic [NUM_CH-1:0] ak,
                      input logic en, input logic clr);
    req_i = rq;
    ack_i = ak;
    en_i  = en;
`ifdef REQ_ACK_MON_STICKY_EN
    err_clr_i = clr;
`else
    if (clr) begin end
`endif
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    model_edge();
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset(input int cycles);
    req_i = '0;
    ack_i = '0;
    en_i  = 1'b0;
`ifdef REQ_ACK_MON_STICKY_EN
    err_clr_i = 1'b0;
`endif
    rst = 1'b1;
    #1;
    check_all_zero("reset_now");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all_zero("in_reset");
    end
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table, then random ----------------
  logic [NUM_CH-1:0] req_tab [22];
  logic [NUM_CH-1:0] ack_tab [22];

  initial begin
    // edges 1..7: ch0 pass at lat 3, ch1 timeout
    req_tab[0]  = 2'b11; ack_tab[0]  = 2'b00;
    req_tab[1]  = 2'b11; ack_tab[1]  = 2'b00;
    req_tab[2]  = 2'b11; ack_tab[2]  = 2'b00;
    req_tab[3]  = 2'b11; ack_tab[3]  = 2'b01;
    req_tab[4]  = 2'b11; ack_tab[4]  = 2'b01;
    req_tab[5]  = 2'b11; ack_tab[5]  = 2'b01;
    req_tab[6]  = 2'b00; ack_tab[6]  = 2'b00;
    // edges 8..11: ch0 early ack
    req_tab[7]  = 2'b01; ack_tab[7]  = 2'b00;
    req_tab[8]  = 2'b01; ack_tab[8]  = 2'b01;
    req_tab[9]  = 2'b00; ack_tab[9]  = 2'b00;
    req_tab[10] = 2'b00; ack_tab[10] = 2'b00;
    // edges 12..13: stray ack on ch1
    req_tab[11] = 2'b00; ack_tab[11] = 2'b10;
    req_tab[12] = 2'b00; ack_tab[12] = 2'b00;
    // edges 14..19: overlap on ch0, then pass at lat 4
    req_tab[13] = 2'b01; ack_tab[13] = 2'b00;
    req_tab[14] = 2'b00; ack_tab[14] = 2'b00;
    req_tab[15] = 2'b01; ack_tab[15] = 2'b00;
    req_tab[16] = 2'b01; ack_tab[16] = 2'b00;
    req_tab[17] = 2'b01; ack_tab[17] = 2'b01;
    req_tab[18] = 2'b00; ack_tab[18] = 2'b00;
    // edges 20..22: start ch0, then reset mid-flight
    req_tab[19] = 2'b01; ack_tab[19] = 2'b00;
    req_tab[20] = 2'b01; ack_tab[20] = 2'b00;
    req_tab[21] = 2'b01; ack_tab[21] = 2'b00;
  end

  initial begin
    rst   = 1'b1;
    req_i = '0;
    ack_i = '0;
    en_i  = 1'b0;
`ifdef REQ_ACK_MON_STICKY_EN
    err_clr_i = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rst = 1'b0;

    for (int k = 0; k < 22; k++) begin
      step(req_tab[k], ack_tab[k], 1'b1, 1'b0);
      case (cyc)
        5: begin
          check("pin_pass_e5", 64'(pass_o), 64'h1);
          check("pin_busy_e5", 64'(busy_o), 64'h2);
        end
        6: begin
          check("pin_timeout_fail", 64'(fail_o), 64'h2);
          check("pin_timeout_code", 64'(fail_code_o), 64'h10);
          check("pin_timeout_busy", 64'(busy_o), 64'h0);
          check("pin_pcnt_e6", 64'(pass_cnt_o), 64'd1);
        end
        7:  check("pin_fcnt_e7", 64'(fail_cnt_o), 64'd1);
        10: begin
          check("pin_early_fail", 64'(fail_o), 64'h1);
          check("pin_early_code", 64'(fail_code_o), 64'h1);
        end
        11: check("pin_no_pass_after_early", 64'(pass_o), 64'h0);
        13: check("pin_stray_code", 64'(fail_code_o), 64'h20);
        17: begin
          check("pin_overlap_code", 64'(fail_code_o), 64'h3);
          check("pin_overlap_busy", 64'(busy_o), 64'h1);
        end
        19: check("pin_pass_after_overlap", 64'(pass_o), 64'h1);
        default: begin end
      endcase
    end
`ifdef REQ_ACK_MON_STICKY_EN
    check("pin_sticky_held", 64'(err_sticky_o), 64'h3);
    step(2'b00, 2'b00, 1'b1, 1'b1);
    check("pin_sticky_cleared", 64'(err_sticky_o), 64'h0);
`endif
    // ch0 transaction in flight; reset must abort it without pulses
    do_reset(2);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("pin_no_pulse_after_reset", 64'(pass_o | fail_o), 64'h0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        logic [NUM_CH-1:0] rq, ak;
        for (int c = 0; c < NUM_CH; c++) begin
          rq[c] = ($urandom_range(0, 3) == 0);
          ak[c] = ($urandom_range(0, 2) == 0);
        end
        step(rq, ak, ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
